// File: rtl/watch_pkg.sv
// Shared types, default parameters and digit-stepping helpers for the
// watch time-setting path.
package watch_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DEF_N_DIG    = 4;
  localparam logic [15:0] DEF_DIG_MOD  = {4'd10, 4'd6, 4'd10, 4'd6};
  localparam int unsigned DEF_DEB_CYC  = 1200000;
  localparam int unsigned DEF_HOLD_CYC = 50000000;
  localparam int unsigned DEF_REP_CYC  = 10000000;

  // Advance one digit modulo m; a stored value at or above the modulus wraps to 0.
  function automatic bcd_t bcd_step(input bcd_t d, input bcd_t m);
    bcd_t r;
    if (d >= (m - 4'd1)) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

  // 24h hour pair: tens steps first, then units against the new tens limit.
  function automatic logic [7:0] hour_step(input bcd_t t, input bcd_t u,
                                           input logic st, input logic su);
    bcd_t nt;
    bcd_t nu;
    nt = t;
    nu = u;
    if (st) begin
      nt = bcd_step(t, 4'd3);
      if ((nt == 4'd2) && (u > 4'd3)) begin
        nu = 4'd3;
      end else begin
        nu = u;
      end
    end else begin
      nt = t;
    end
    if (su) begin
      nu = bcd_step(nu, (nt == 4'd2) ? 4'd4 : 4'd10);
    end else begin
      nu = nu;
    end
    return {nt, nu};
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One button: 2-FF synchroniser, debounce, press detect and hold-to-repeat.
// Produces a single-cycle step pulse for each press and each repeat.
module btn_conditioner
  import watch_pkg::*;
#(
  parameter int unsigned DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned REP_CYC  = DEF_REP_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic step_o
);

  localparam int unsigned DW   = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned RMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int unsigned RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REP_CYC - 1);

  logic [1:0]    sync_q,    sync_d;
  logic          stable_q,  stable_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          first_q,   first_d;
  logic          step_q,    step_d;
  logic          accept_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
      rep_cnt_q <= '0;
      first_q   <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      first_q   <= first_d;
      step_q    <= step_d;
    end
  end

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_comb begin
    sync_d    = {sync_q[0], ~btn_n_i};
    stable_d  = stable_q;
    deb_cnt_d = '0;
    accept_s  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        accept_s = 1'b1;
        stable_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end else begin
      deb_cnt_d = '0;
    end
  end

  // first_q selects the long initial hold interval before the repeat cadence.
  always_comb begin
    step_d    = 1'b0;
    rep_cnt_d = rep_cnt_q;
    first_d   = first_q;
    if (accept_s) begin
      step_d    = stable_d;
      rep_cnt_d = '0;
      first_d   = 1'b1;
    end else if (stable_q) begin
      if (rep_cnt_q == (first_q ? HOLD_LAST : REP_LAST)) begin
        step_d    = 1'b1;
        rep_cnt_d = '0;
        first_d   = 1'b0;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end else begin
      rep_cnt_d = '0;
      first_d   = 1'b0;
    end
  end

  assign step_o = step_q;

endmodule

// File: rtl/time_set_ctrl.sv
// Digit-setting controller: one conditioned button per BCD digit, optional
// 24h hour-pair coupling, load override and change pulse.
module time_set_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned         N_DIG    = DEF_N_DIG,
  parameter logic [4*N_DIG-1:0]  DIG_MOD  = DEF_DIG_MOD,
  parameter int unsigned         DEB_CYC  = DEF_DEB_CYC,
  parameter int unsigned         HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned         REP_CYC  = DEF_REP_CYC,
  parameter bit                  HOUR24   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [N_DIG-1:0]     btn,
  input  logic                 load,
  input  logic [4*N_DIG-1:0]   load_val,
  output logic [4*N_DIG-1:0]   dig,
  output logic                 changed
);

  localparam bit          HOUR24_ON = HOUR24 && (N_DIG >= 2);
  localparam int unsigned HT        = (N_DIG >= 2) ? N_DIG - 1 : 0;
  localparam int unsigned HU        = (N_DIG >= 2) ? N_DIG - 2 : 0;

  logic [N_DIG-1:0]   step_s;
  logic [N_DIG-1:0]   step_en_s;
  logic [4*N_DIG-1:0] dig_q, dig_d;
  logic               changed_q, changed_d;
  logic [7:0]         hour_s;

  for (genvar g = 0; g < N_DIG; g++) begin : g_cond
    btn_conditioner #(
      .DEB_CYC  (DEB_CYC),
      .HOLD_CYC (HOLD_CYC),
      .REP_CYC  (REP_CYC)
    ) u_cond (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (btn[g]),
      .step_o  (step_s[g])
    );
  end

  // Steps outside edit mode are dropped, not deferred.
  assign step_en_s = step_s & {N_DIG{set_en}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      dig_q     <= dig_d;
      changed_q <= changed_d;
    end
  end

  // Load wins over every step; otherwise all stepped digits advance together.
  always_comb begin
    dig_d  = dig_q;
    hour_s = 8'd0;
    if (load) begin
      dig_d = load_val;
    end else begin
      for (int i = 0; i < int'(N_DIG); i++) begin
        if (step_en_s[i] && !(HOUR24_ON && ((i == int'(HT)) || (i == int'(HU))))) begin
          dig_d[4*i +: 4] = bcd_step(dig_q[4*i +: 4], DIG_MOD[4*i +: 4]);
        end else begin
          dig_d[4*i +: 4] = dig_q[4*i +: 4];
        end
      end
      if (HOUR24_ON) begin
        hour_s = hour_step(dig_q[4*HT +: 4], dig_q[4*HU +: 4],
                           step_en_s[HT], step_en_s[HU]);
        dig_d[4*HT +: 4] = hour_s[7:4];
        dig_d[4*HU +: 4] = hour_s[3:0];
      end else begin
        hour_s = 8'd0;
      end
    end
  end

  assign changed_d = (dig_d != dig_q);
  assign dig       = dig_q;
  assign changed   = changed_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised and directed bench for time_set_ctrl (12h and 24h builds side by
// side) against a behavioural model of press/repeat timing and digit rules.
module tb_time_set_ctrl;

  localparam int ND   = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 5;
  localparam logic [15:0] MODS = 16'hA6A6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        set_en = 1'b1;
  logic [3:0]  btn = 4'hF;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] dig0, dig24;
  logic        chg0, chg24;

  int n_vec = 0;
  int n_err = 0;
  int chg_cnt = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.N_DIG(ND), .DIG_MOD(MODS), .DEB_CYC(DEB), .HOLD_CYC(HOLD),
                  .REP_CYC(REP), .HOUR24(1'b0)) dut0 (
    .clk(clk), .rst(rst), .set_en(set_en), .btn(btn), .load(load),
    .load_val(load_val), .dig(dig0), .changed(chg0));

  time_set_ctrl #(.N_DIG(ND), .DIG_MOD(MODS), .DEB_CYC(DEB), .HOLD_CYC(HOLD),
                  .REP_CYC(REP), .HOUR24(1'b1)) dut24 (
    .clk(clk), .rst(rst), .set_en(set_en), .btn(btn), .load(load),
    .load_val(load_val), .dig(dig24), .changed(chg24));

  // ---------------- behavioural model ----------------
  bit          s1 [ND];
  bit          s2 [ND];
  bit          acc [ND];
  bit          hist [ND][DEB];
  int          press_t [ND];
  bit [ND-1:0] pend;
  int          mcyc;
  logic [15:0] m_dig [2];
  bit          m_chg [2];

  function automatic logic [15:0] model_next(input logic [15:0] d, input bit [ND-1:0] st,
                                             input bit h24, input bit en, input bit ld,
                                             input logic [15:0] lv);
    int v [ND];
    int m;
    int lim;
    logic [15:0] mods_v;
    logic [15:0] r;
    mods_v = MODS;
    r = d;
    if (ld) return lv;
    for (int i = 0; i < ND; i++) v[i] = int'(d[4*i +: 4]);
    if (en) begin
      for (int i = 0; i < ND; i++) begin
        m = int'(mods_v[4*i +: 4]);
        if (st[i] && !(h24 && i >= ND-2)) v[i] = (v[i] + 1 >= m) ? 0 : v[i] + 1;
      end
      if (h24) begin
        if (st[ND-1]) begin
          v[ND-1] = (v[ND-1] + 1 >= 3) ? 0 : v[ND-1] + 1;
          if (v[ND-1] == 2 && v[ND-2] > 3) v[ND-2] = 3;
        end
        if (st[ND-2]) begin
          lim = (v[ND-1] == 2) ? 4 : 10;
          v[ND-2] = (v[ND-2] + 1 >= lim) ? 0 : v[ND-2] + 1;
        end
      end
    end
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'(v[i]);
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < ND; i++) begin
          s1[i] = 1'b0; s2[i] = 1'b0; acc[i] = 1'b0; press_t[i] = 0;
          for (int j = 0; j < DEB; j++) hist[i][j] = 1'b0;
        end
        pend = '0;
        mcyc = 0;
        for (int k = 0; k < 2; k++) begin m_dig[k] = 16'h0000; m_chg[k] = 1'b0; end
      end else begin
        bit [ND-1:0] npend;
        bit same;
        logic [15:0] nd;
        mcyc++;
        for (int k = 0; k < 2; k++) begin
          nd = model_next(m_dig[k], pend, (k == 1), set_en, load, load_val);
          m_chg[k] = (nd != m_dig[k]);
          m_dig[k] = nd;
        end
        npend = '0;
        for (int i = 0; i < ND; i++) begin
          for (int j = DEB-1; j > 0; j--) hist[i][j] = hist[i][j-1];
          hist[i][0] = s2[i];
          same = 1'b1;
          for (int j = 0; j < DEB; j++) if (hist[i][j] != hist[i][0]) same = 1'b0;
          if (same && hist[i][0] != acc[i]) begin
            acc[i] = hist[i][0];
            if (acc[i]) begin press_t[i] = mcyc; npend[i] = 1'b1; end
          end else if (acc[i]) begin
            int dt;
            dt = mcyc - press_t[i];
            if (dt >= HOLD && ((dt - HOLD) % REP) == 0) npend[i] = 1'b1;
          end
          s2[i] = s1[i];
          s1[i] = ~btn[i];
        end
        pend = npend;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if (dig0 !== m_dig[0] || chg0 !== m_chg[0]) begin
        n_err++;
        $display("FAIL cmp12 t=%0t: dig=%h chg=%b expected dig=%h chg=%b",
                 $time, dig0, chg0, m_dig[0], m_chg[0]);
      end
      n_vec++;
      if (dig24 !== m_dig[1] || chg24 !== m_chg[1]) begin
        n_err++;
        $display("FAIL cmp24 t=%0t: dig=%h chg=%b expected dig=%h chg=%b",
                 $time, dig24, chg24, m_dig[1], m_chg[1]);
      end
      if (chg0 === 1'b1) chg_cnt++;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b0;
    tick(hold);
    btn[b] = 1'b1;
    tick(10);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_val = v;
    tick(1);
    load = 1'b0;
    tick(1);
  endtask

  int base;
  logic [3:0] bounce [5];

  initial begin
    rst = 1'b1;
    tick(3);
    check("reset_dig12", dig0, 16'h0000);
    check("reset_dig24", dig24, 16'h0000);
    rst = 1'b0;
    tick(2);

    // bounced press on btn[0]
    bounce[0] = 4'hE; bounce[1] = 4'hF; bounce[2] = 4'hE; bounce[3] = 4'hF; bounce[4] = 4'hE;
    for (int i = 0; i < 5; i++) begin btn = bounce[i]; tick(1); end
    tick(10);
    btn = 4'hF;
    tick(10);
    check("bounce_step", dig0, 16'h0001);
    check("bounce_model", m_dig[0], 16'h0001);

    // six clean presses, modulus 6
    do_load(16'h0000);
    base = chg_cnt;
    for (int p = 1; p <= 6; p++) begin
      press(0, 10);
      check($sformatf("press%0d", p), dig0, 16'((p % 6)));
    end
    check("changed_pulses", 16'(chg_cnt - base), 16'd6);

    // hold btn[1]: press plus four repeats
    do_load(16'h0000);
    press(1, 37);
    check("hold12", dig0, 16'h0050);
    check("hold24", dig24, 16'h0050);

    // 24h hour pair
    do_load(16'h1900);
    press(3, 10);
    check("h24_tens", dig24, 16'h2300);
    check("h24_tens_model", m_dig[1], 16'h2300);
    check("h12_tens", dig0, 16'h2900);
    press(2, 10);
    check("h24_units", dig24, 16'h2000);
    check("h12_units", dig0, 16'h2000);

    // edit disabled
    set_en = 1'b0;
    press(2, 10);
    set_en = 1'b1;
    check("seten12", dig0, 16'h2000);
    check("seten24", dig24, 16'h2000);

    // load overlaps the step
    btn[0] = 1'b0;
    tick(3);
    load = 1'b1; load_val = 16'h1234;
    tick(6);
    load = 1'b0;
    tick(1);
    btn[0] = 1'b1;
    tick(10);
    check("load12", dig0, 16'h1234);
    check("load24", dig24, 16'h1234);

    // reset mid-repeat, button still held afterwards
    btn[1] = 1'b0;
    tick(30);
    rst = 1'b1;
    #1;
    check("arst_dig12", dig0, 16'h0000);
    check("arst_chg12", 16'(chg0), 16'h0000);
    check("arst_dig24", dig24, 16'h0000);
    check("arst_chg24", 16'(chg24), 16'h0000);
    tick(2);
    rst = 1'b0;
    tick(12);
    check("repress12", dig0, 16'h0010);
    check("repress24", dig24, 16'h0010);
    btn[1] = 1'b1;
    tick(10);

    // random phase
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < ND; i++)
        if ($urandom_range(0, 23) == 0) btn[i] = ~btn[i];
      set_en = ($urandom_range(0, 19) != 0);
      load = ($urandom_range(0, 63) == 0);
      load_val = 16'($urandom);
      rst = (rst == 1'b0) && ($urandom_range(0, 999) == 0);
      tick(1);
    end
    rst = 1'b0;
    load = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
